blink_rtc: RTL and testbench
============================

BLINK_RTC -- requirements
Module: blink_rtc

Interface
REQ-001 Parameter TICK_DIV, default 49152: number of mck cycles per 5 ms tick; legal range 2..65535.
REQ-002 Parameter TICKS_PER_SEC, default 200: number of ticks per second; legal range 2..256.
REQ-003 Parameter MIN_W, default 21: minutes counter width; legal range 17..24.
REQ-004 Port mck, input, 1: single clock (9.83 MHz master); reset is synchronous and active-high.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port restim, input, 1: level-sensitive timer reset (COM RESTIM bit).
REQ-007 Port wr, input, 1: register write strobe, one cycle.
REQ-008 Port rd, input, 1: register read strobe, one cycle.
REQ-009 Port addr, input, 8: I/O register address.
REQ-010 Port wdata, input, 8: write data.
REQ-011 Port rdata, output, 8: registered read data.
REQ-012 Port rd_hit, output, 1: pulse indicating that rdata is valid and the address was decoded.
REQ-013 Port tsta, output, 3 (4 with RTC_ALARM_EN): timer status.
REQ-014 Port rtc_int, output, 1: high when (tsta & tmk) is non-zero.

Function
REQ-015 Prescaler counts 0..TICK_DIV-1, then wraps; a tick occurs on the wrap cycle.
REQ-016 On a tick, tim0 increments; at TICKS_PER_SEC-1 it wraps to 0 and generates a second event.
REQ-017 On a second event, tim1 increments; at 59 it wraps to 0 and generates a minute event.
REQ-018 On a minute event, timm (MIN_W bits) increments; at all-ones it wraps to 0 with no additional event.
REQ-019 Tick, second and minute events set tsta[0], tsta[1] and tsta[2] respectively in the same edge as the counter update.
REQ-020 A write to 0xB4 clears each tsta bit where the corresponding wdata bit is 1; if a set and a clear hit the same bit in the same cycle, set wins.
REQ-021 A write to 0xB5 loads tmk from wdata[2:0] (wdata[3:0] with RTC_ALARM_EN).
REQ-022 Reads: 0xB5 returns tsta zero-extended; 0xD0 returns tim0; 0xD1 returns {2'b0, tim1}; 0xD2/0xD3 return timm[7:0]/[15:8]; 0xD4 returns timm[MIN_W-1:16] zero-extended.
REQ-023 Read latency is 1 cycle: rdata and rd_hit update on the edge after rd; rd_hit pulses for 1 cycle only on decoded addresses; rdata holds its value otherwise.
REQ-024 Snapshot: a read of 0xD0 copies tim1 and timm into shadow registers in the same edge; reads of 0xD1..0xD4 return the shadow, giving a coherent multi-byte time despite a rollover between reads.
REQ-025 While restim=1, prescaler, tim0, tim1 and timm are held at 0 and no events are generated; tsta, tmk and the shadows keep their values.
REQ-026 Counting resumes on the first cycle after restim falls; the first tick occurs TICK_DIV cycles later.
REQ-027 rd and wr are mutually exclusive; if both are asserted, wr takes effect and the read is ignored (rd_hit stays 0).

Reset
REQ-028 While rst=1: prescaler, tim0, tim1, timm, shadows, tsta, tmk, rdata and rd_hit are 0, so rtc_int=0; rst overrides restim and all strobes.

Configuration
REQ-029 With macro BLINK_RTC_ALARM_EN defined: an alarm register alm (MIN_W bits) is written byte-wise at 0xB8/0xB9/0xBA (the top byte masked to MIN_W), and tsta[3] sets on the minute event where the new timm equals alm.
REQ-030 With BLINK_RTC_ALARM_EN defined: alm resets to all-ones, and the 0xB8..0xBA addresses are undecoded for reads.
REQ-031 Without BLINK_RTC_ALARM_EN: tsta and tmk are 3 bits, writes to 0xB8..0xBA are ignored, and no alarm logic is present.

Structure
REQ-032 Package blink_pkg holds the register address constants (B4, B5, B8..BA, D0..D4) and the TSTA bit indices.
REQ-033 One sub-module, blink_rtc_cnt, is a generic modulo-N counter with enable, clear and wrap output, instanced for the prescaler, tim0 and tim1.

Verification
REQ-034 TICK_DIV=4, TICKS_PER_SEC=4, tmk=7 -> tsta[0] sets 4 cycles after reset release, rtc_int=1 the same cycle; tsta[1] sets after 16 cycles.
REQ-035 Write 0xB4=0x01 on the cycle of a tick -> tsta[0] remains 1 (set wins); on a later non-tick write tsta[0] clears and rtc_int drops.
REQ-036 Preload timm=2^21-1, tim1=59, tim0=199, then a tick -> timm=0, tim1=0, tim0=0, and tsta[2:0]=7.
REQ-037 Read 0xD0, let a minute rollover occur, then read 0xD2 -> rdata returns the pre-rollover timm[7:0]; rd_hit=1 one cycle after each rd.
REQ-038 restim held high for 10 cycles mid-count -> counters read 0; the first tick comes exactly TICK_DIV cycles after release; tsta is unchanged.
REQ-039 With BLINK_RTC_ALARM_EN, alm=3, tmk=8 -> tsta[3] and rtc_int assert at the third minute event and at no other.

Source files
------------

// File: rtl/blink_pkg.sv
// blink_pkg -- shared constants for the blink_rtc timer block.
//
// Holds the I/O register map and the bit positions inside the timer status
// register (tsta). The status width depends on the optional alarm feature,
// which is enabled by defining the macro BLINK_RTC_ALARM_EN.
package blink_pkg;

`ifdef BLINK_RTC_ALARM_EN
  localparam int TSTA_W = 4;
`else
  localparam int TSTA_W = 3;
`endif

  // Write-side registers
  localparam logic [7:0] ADDR_TSTA_CLR = 8'hB4;  // write: clear tsta bits
  localparam logic [7:0] ADDR_TMK      = 8'hB5;  // write: tmk, read: tsta
  localparam logic [7:0] ADDR_ALM0     = 8'hB8;  // alarm minutes [7:0]
  localparam logic [7:0] ADDR_ALM1     = 8'hB9;  // alarm minutes [15:8]
  localparam logic [7:0] ADDR_ALM2     = 8'hBA;  // alarm minutes [MIN_W-1:16]

  // Read-side time registers
  localparam logic [7:0] ADDR_TIM0     = 8'hD0;  // ticks (also takes the snapshot)
  localparam logic [7:0] ADDR_TIM1     = 8'hD1;  // seconds (snapshot)
  localparam logic [7:0] ADDR_TIMM0    = 8'hD2;  // minutes [7:0] (snapshot)
  localparam logic [7:0] ADDR_TIMM1    = 8'hD3;  // minutes [15:8] (snapshot)
  localparam logic [7:0] ADDR_TIMM2    = 8'hD4;  // minutes [MIN_W-1:16] (snapshot)

  // tsta bit indices
  localparam int TSTA_TICK = 0;
  localparam int TSTA_SEC  = 1;
  localparam int TSTA_MIN  = 2;
  localparam int TSTA_ALM  = 3;

endpackage

// File: rtl/blink_rtc_cnt.sv
// blink_rtc_cnt -- modulo-N counter with enable, clear and wrap strobe.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (count -> 0)
//   clr  : synchronous hold-at-zero; suppresses wrap while high
//   en   : advance the count by one
//   cnt  : current count, 0..N-1
//   wrap : high in the cycle where an enabled count leaves N-1 (returns to 0)
module blink_rtc_cnt #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap = en && !clr && (cnt_q == W'(N - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/blink_rtc.sv
// blink_rtc -- 5 ms tick / second / minute real-time counter with status,
// interrupt mask and a byte-wide register port.
//
// Ports:
//   mck     : master clock
//   rst     : synchronous active-high reset
//   restim  : level timer reset; holds all time counters at zero
//   wr, rd  : one-cycle register strobes (wr has priority)
//   addr    : register address, wdata : write data
//   rdata   : registered read data, held between decoded reads
//   rd_hit  : one-cycle pulse alongside rdata for a decoded read
//   tsta    : status bits {alarm,} minute, second, tick
//   rtc_int : any status bit that is also enabled in tmk
//
// Optional feature: define BLINK_RTC_ALARM_EN to add a minutes alarm register
// (0xB8..0xBA) and the alarm status bit tsta[3].
module blink_rtc
  import blink_pkg::*;
#(
  parameter int TICK_DIV      = 49152,
  parameter int TICKS_PER_SEC = 200,
  parameter int MIN_W         = 21
) (
  input  logic              mck,
  input  logic              rst,
  input  logic              restim,
  input  logic              wr,
  input  logic              rd,
  input  logic [7:0]        addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              rd_hit,
  output logic [TSTA_W-1:0] tsta,
  output logic              rtc_int
);

  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TIM0_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [PRE_W-1:0]  pre_cnt_unused;
  logic [TIM0_W-1:0] tim0_cnt;
  logic [5:0]        tim1_cnt;
  logic              tick, sec_evt, min_evt;

  // Event chain: each stage advances only on the previous stage's wrap, and
  // restim clears every stage, which also keeps all wrap strobes low.
  blink_rtc_cnt #(.N(TICK_DIV), .W(PRE_W)) u_pre (
    .clk(mck), .rst(rst), .clr(restim), .en(1'b1),
    .cnt(pre_cnt_unused), .wrap(tick)
  );

  blink_rtc_cnt #(.N(TICKS_PER_SEC), .W(TIM0_W)) u_tim0 (
    .clk(mck), .rst(rst), .clr(restim), .en(tick),
    .cnt(tim0_cnt), .wrap(sec_evt)
  );

  blink_rtc_cnt #(.N(60), .W(6)) u_tim1 (
    .clk(mck), .rst(rst), .clr(restim), .en(sec_evt),
    .cnt(tim1_cnt), .wrap(min_evt)
  );

  logic [MIN_W-1:0]  timm_q, timm_d, timm_inc;
  logic [TSTA_W-1:0] tsta_q, tsta_d, tsta_set, tsta_clr;
  logic [TSTA_W-1:0] tmk_q, tmk_d;
  logic [5:0]        sh_tim1_q, sh_tim1_d;
  logic [MIN_W-1:0]  sh_timm_q, sh_timm_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              rd_hit_q, rd_hit_d;
  logic              rd_en;

  // Minutes roll over silently from all-ones to zero.
  assign timm_inc = timm_q + MIN_W'(1);
  assign rd_en    = rd && !wr;

`ifdef BLINK_RTC_ALARM_EN
  logic [MIN_W-1:0] alm_q, alm_d;

  always_comb begin
    alm_d = alm_q;
    if (wr) begin
      case (addr)
        ADDR_ALM0: alm_d[7:0]        = wdata;
        ADDR_ALM1: alm_d[15:8]       = wdata;
        ADDR_ALM2: alm_d[MIN_W-1:16] = wdata[MIN_W-17:0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge mck) begin
    if (rst) begin
      alm_q <= '1;
    end else begin
      alm_q <= alm_d;
    end
  end
`else
  // Write data bits above the 3-bit status/mask width are don't-care.
  logic wdata_unused;
  assign wdata_unused = ^wdata;
`endif

  always_comb begin
    timm_d = timm_q;
    if (restim) begin
      timm_d = '0;
    end else if (min_evt) begin
      timm_d = timm_inc;
    end
  end

  // Status: a set in the same cycle as a clear wins, hence set is OR'd last.
  always_comb begin
    tsta_set            = '0;
    tsta_set[TSTA_TICK] = tick;
    tsta_set[TSTA_SEC]  = sec_evt;
    tsta_set[TSTA_MIN]  = min_evt;
`ifdef BLINK_RTC_ALARM_EN
    tsta_set[TSTA_ALM]  = min_evt && (timm_inc == alm_q);
`endif
    tsta_clr = (wr && addr == ADDR_TSTA_CLR) ? wdata[TSTA_W-1:0] : '0;
    tsta_d   = (tsta_q & ~tsta_clr) | tsta_set;
    tmk_d    = (wr && addr == ADDR_TMK) ? wdata[TSTA_W-1:0] : tmk_q;
  end

  // Read decode. A tim0 read freezes tim1/timm in the shadows so the
  // remaining bytes describe the same instant even across a rollover.
  always_comb begin
    rdata_d   = rdata_q;
    rd_hit_d  = 1'b0;
    sh_tim1_d = sh_tim1_q;
    sh_timm_d = sh_timm_q;
    if (rd_en) begin
      rd_hit_d = 1'b1;
      case (addr)
        ADDR_TMK:   rdata_d = 8'(tsta_q);
        ADDR_TIM0: begin
          rdata_d   = 8'(tim0_cnt);
          sh_tim1_d = tim1_cnt;
          sh_timm_d = timm_q;
        end
        ADDR_TIM1:  rdata_d = {2'b00, sh_tim1_q};
        ADDR_TIMM0: rdata_d = sh_timm_q[7:0];
        ADDR_TIMM1: rdata_d = sh_timm_q[15:8];
        ADDR_TIMM2: rdata_d = 8'(sh_timm_q[MIN_W-1:16]);
        default:    rd_hit_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge mck) begin
    if (rst) begin
      timm_q    <= '0;
      tsta_q    <= '0;
      tmk_q     <= '0;
      sh_tim1_q <= '0;
      sh_timm_q <= '0;
      rdata_q   <= '0;
      rd_hit_q  <= 1'b0;
    end else begin
      timm_q    <= timm_d;
      tsta_q    <= tsta_d;
      tmk_q     <= tmk_d;
      sh_tim1_q <= sh_tim1_d;
      sh_timm_q <= sh_timm_d;
      rdata_q   <= rdata_d;
      rd_hit_q  <= rd_hit_d;
    end
  end

  assign rdata   = rdata_q;
  assign rd_hit  = rd_hit_q;
  assign tsta    = tsta_q;
  assign rtc_int = |(tsta_q & tmk_q);

endmodule

// File: tb/tb_blink_rtc.sv
// tb_blink_rtc -- bench for blink_rtc with TICK_DIV=4, TICKS_PER_SEC=4, so a
// tick is every 4 cycles, a second every 16 and a minute every 960 cycles.
// Reads push their expected data into a scoreboard; a monitor pops it on the
// cycle the DUT presents rd_hit. Status pins are checked directly.
module tb_blink_rtc;
  import blink_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int TPS      = 4;
  localparam int MIN_W    = 21;

  logic              mck    = 1'b0;
  logic              rst    = 1'b1;
  logic              restim = 1'b0;
  logic              wr     = 1'b0;
  logic              rd     = 1'b0;
  logic [7:0]        addr   = 8'h00;
  logic [7:0]        wdata  = 8'h00;
  logic [7:0]        rdata;
  logic              rd_hit;
  logic [TSTA_W-1:0] tsta;
  logic              rtc_int;

  int cyc;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] last_rd = 8'h00;

  typedef struct {
    int         due;
    logic [7:0] a;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  blink_rtc #(.TICK_DIV(TICK_DIV), .TICKS_PER_SEC(TPS), .MIN_W(MIN_W)) dut (
    .mck(mck), .rst(rst), .restim(restim), .wr(wr), .rd(rd),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rd_hit(rd_hit),
    .tsta(tsta), .rtc_int(rtc_int)
  );

  always #5 mck = ~mck;

  // cyc = number of rising edges since reset release (valid at each negedge)
  always @(posedge mck) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic goto(input int t);
    while (cyc < t) @(negedge mck);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, got, exp);
    end else begin
      $display("chk %-20s @cyc %0d: 0x%0h ok", nm, cyc, got);
    end
  endtask

  task automatic do_wr(input logic [7:0] a, input logic [7:0] d);
    $display("wr addr=0x%02h data=0x%02h @cyc %0d", a, d, cyc);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge mck);
    wr = 1'b0;
  endtask

  task automatic do_rd(input logic [7:0] a, input logic [7:0] exp);
    exp_t e;
    e.due = cyc + 1; e.a = a; e.val = exp;
    sb.push_back(e);
    last_rd = exp;
    addr = a; rd = 1'b1;
    @(negedge mck);
    rd = 1'b0;
  endtask

  // Monitor: every decoded read must show up exactly one cycle after its strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge mck);
      if (!rst) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
          e = sb.pop_front();
          n_cmp++;
          if (rd_hit !== 1'b1 || rdata !== e.val) begin
            n_err++;
            $display("FAIL rd 0x%02h @cyc %0d: rd_hit=%b rdata=0x%02h, expected rd_hit=1 rdata=0x%02h",
                     e.a, cyc, rd_hit, rdata, e.val);
          end else begin
            $display("rd 0x%02h @cyc %0d: rdata=0x%02h ok", e.a, cyc, rdata);
          end
        end else if (rd_hit !== 1'b0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious rd_hit @cyc %0d: rd_hit=%b rdata=0x%02h, expected rd_hit=0",
                   cyc, rd_hit, rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset dominates strobes and restim
    repeat (2) @(negedge mck);
    addr = ADDR_TIM0; rd = 1'b1; restim = 1'b1;
    @(negedge mck);
    rd = 1'b0; restim = 1'b0;
    check("reset rd_hit", 32'(rd_hit), 0);
    check("reset rdata", 32'(rdata), 0);
    check("reset tsta", 32'(tsta), 0);
    check("reset rtc_int", 32'(rtc_int), 0);
    rst = 1'b0;

    // First tick 4 edges after release, first second at 16
    do_wr(ADDR_TMK, 8'h07);
    goto(3);  check("tsta before tick", 32'(tsta), 0);
              check("int before tick", 32'(rtc_int), 0);
    goto(4);  check("tsta first tick", 32'(tsta), 1);
              check("int first tick", 32'(rtc_int), 1);
    goto(15); check("tsta before sec", 32'(tsta), 1);
    goto(16); check("tsta first sec", 32'(tsta), 3);

    // Clear coinciding with a tick: set wins; later clears take effect
    goto(19); do_wr(ADDR_TSTA_CLR, 8'h01);
    check("set wins", 32'(tsta), 3);
    goto(21); do_wr(ADDR_TSTA_CLR, 8'h01);
    check("clear bit0", 32'(tsta), 2);
    check("int bit1 only", 32'(rtc_int), 1);
    do_wr(ADDR_TSTA_CLR, 8'h02);
    check("clear bit1", 32'(tsta), 0);
    check("int dropped", 32'(rtc_int), 0);

    // Register reads at t=25..30
    goto(25);
    do_rd(ADDR_TIM0, 8'd2);
    do_rd(ADDR_TIM1, 8'd1);
    do_rd(ADDR_TIMM0, 8'd0);
    do_rd(ADDR_TIMM1, 8'd0);
    do_rd(ADDR_TIMM2, 8'd0);
    do_rd(ADDR_TMK, 8'd1);

    // Undecoded read, then rd+wr together: no rd_hit, rdata held
    addr = ADDR_TSTA_CLR; rd = 1'b1;
    @(negedge mck);
    rd = 1'b0;
    check("undecoded rd_hit", 32'(rd_hit), 0);
    check("undecoded rdata", 32'(rdata), 32'(last_rd));
    addr = ADDR_TMK; wdata = 8'h07; wr = 1'b1; rd = 1'b1;
    @(negedge mck);
    wr = 1'b0; rd = 1'b0;
    check("rd+wr rd_hit", 32'(rd_hit), 0);
    check("rd+wr rdata", 32'(rdata), 32'(last_rd));

    // Snapshot across the minute rollover at t=960
    goto(955);
    do_rd(ADDR_TIM0, 8'd2);
    do_rd(ADDR_TIM1, 8'd59);
    goto(958); do_wr(ADDR_TSTA_CLR, 8'h07);
    check("tsta cleared pre-min", 32'(tsta), 0);
    goto(960); check("tsta minute", 32'(tsta), 7);
               check("int minute", 32'(rtc_int), 1);
    goto(961);
    do_rd(ADDR_TIMM0, 8'd0);
    do_rd(ADDR_TIM0, 8'd0);
    do_rd(ADDR_TIM1, 8'd0);
    do_rd(ADDR_TIMM0, 8'd1);

    // restim for 10 edges (971..980)
    do_wr(ADDR_TSTA_CLR, 8'h07);
    goto(967); check("tsta cleared", 32'(tsta), 0);
    goto(968); check("tsta tick 968", 32'(tsta), 1);
    goto(970); restim = 1'b1;
    goto(975);
    do_rd(ADDR_TIM0, 8'd0);
    do_rd(ADDR_TIM1, 8'd0);
    do_rd(ADDR_TMK, 8'd1);
    do_wr(ADDR_TSTA_CLR, 8'h01);
    do_rd(ADDR_TMK, 8'd0);
    restim = 1'b0;
    goto(983); check("no tick before 4", 32'(tsta), 0);
    goto(984); check("tick 4 after restim", 32'(tsta), 1);
    goto(985);
    do_rd(ADDR_TIM0, 8'd1);
    do_rd(ADDR_TIMM0, 8'd0);
    do_rd(ADDR_TIM1, 8'd0);

    goto(995);
    check("scoreboard drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
